// File: rtl/bit_reorder_ctrl.sv
// bit_reorder_ctrl: runtime bit-permutation engine with a double-buffered map that swaps only at frame boundaries.
// Optional macro BIT_REORDER_CTRL_PERM_CHECK_EN rejects shadow maps that are not true permutations.
`default_nettype none

module bit_reorder_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_wr_en,
  input  logic [IDX_WIDTH-1:0]  cfg_addr,
  input  logic [IDX_WIDTH-1:0]  cfg_data,
  input  logic                  cfg_commit,
  output logic                  commit_pending,
  output logic                  commit_done,
  output logic                  cfg_err,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  typedef enum logic [0:0] {ARMED = 1'b0, PENDING = 1'b1} state_t;

  state_t                state_q;
  logic                  commit_pending_q;
  logic                  commit_done_q;
  logic                  in_frame_q;
  logic                  m_valid_q;
  logic                  m_last_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic [DATA_WIDTH-1:0] m_data_d;
  logic [IDX_WIDTH-1:0]  shadow_q [DATA_WIDTH];
  logic [IDX_WIDTH-1:0]  active_q [DATA_WIDTH];

  logic accept;
  logic swap;
  logic wr_ok;
  logic perm_ok;

  assign s_ready = !m_valid_q || m_ready;
  assign accept  = s_valid && s_ready;

  // A frame-closing beat still uses the old map; the idle case needs no accept so nothing straddles the swap.
  assign swap = (state_q == PENDING) &&
                ((!in_frame_q && !accept) || (accept && s_last));

  assign wr_ok = cfg_wr_en && !commit_pending_q &&
                 (32'(cfg_addr) < 32'(DATA_WIDTH)) &&
                 (32'(cfg_data) < 32'(DATA_WIDTH));

  always_comb begin
    m_data_d = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      m_data_d[i] = s_data[active_q[i]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        shadow_q[i] <= IDX_WIDTH'(i);
      end
    end else if (wr_ok) begin
      shadow_q[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_last_q   <= 1'b0;
      in_frame_q <= 1'b0;
    end else begin
      if (accept) begin
        m_valid_q  <= 1'b1;
        m_data_q   <= m_data_d;
        m_last_q   <= s_last;
        in_frame_q <= !s_last;
      end else if (m_ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ARMED;
      commit_pending_q <= 1'b0;
      commit_done_q    <= 1'b0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
        active_q[i] <= IDX_WIDTH'(i);
      end
    end else begin
      commit_done_q <= 1'b0;
      case (state_q)
        ARMED: begin
          if (cfg_commit) begin
            state_q          <= PENDING;
            commit_pending_q <= 1'b1;
          end
        end
        PENDING: begin
          if (swap) begin
            state_q          <= ARMED;
            commit_pending_q <= 1'b0;
            if (perm_ok) begin
              active_q      <= shadow_q;
              commit_done_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q          <= ARMED;
          commit_pending_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef BIT_REORDER_CTRL_PERM_CHECK_EN
  logic [DATA_WIDTH-1:0] cover_d;
  logic                  cfg_err_q;

  always_comb begin
    cover_d = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      cover_d[shadow_q[i]] = 1'b1;
    end
  end

  assign perm_ok = &cover_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err_q <= 1'b0;
    end else if (swap) begin
      cfg_err_q <= !perm_ok;
    end
  end

  assign cfg_err = cfg_err_q;
`else
  assign perm_ok = 1'b1;
  assign cfg_err = 1'b0;
`endif

  assign commit_pending = commit_pending_q;
  assign commit_done    = commit_done_q;
  assign m_valid        = m_valid_q;
  assign m_data         = m_data_q;
  assign m_last         = m_last_q;

endmodule

`default_nettype wire

// File: tb/tb_bit_reorder_ctrl.sv
// tb_bit_reorder_ctrl: directed self-checking bench for bit_reorder_ctrl.
`default_nettype none

module tb_bit_reorder_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_wr_en;
  logic [4:0]  cfg_addr;
  logic [4:0]  cfg_data;
  logic        cfg_commit;
  logic        commit_pending;
  logic        commit_done;
  logic        cfg_err;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;

  int n_cmp = 0;
  int n_bad = 0;

  bit_reorder_ctrl #(.DATA_WIDTH(32), .IDX_WIDTH(5)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_wr_en      (cfg_wr_en),
    .cfg_addr       (cfg_addr),
    .cfg_data       (cfg_data),
    .cfg_commit     (cfg_commit),
    .commit_pending (commit_pending),
    .commit_done    (commit_done),
    .cfg_err        (cfg_err),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .s_last         (s_last),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .m_last         (m_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_map(input bit reverse);
    cfg_wr_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      cfg_addr = 5'(i);
      cfg_data = reverse ? 5'(31 - i) : 5'(i);
      step();
    end
    cfg_wr_en = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic last);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    step();
    s_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cfg_wr_en = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_commit = 1'b0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    step(); step();
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", m_data, 32'h0);
    chk("rst_pending", 32'(commit_pending), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    rst_n = 1'b1;
    step();

    // Identity map after reset
    beat(32'h12345678, 1'b1);
    chk("id_m_valid", 32'(m_valid), 32'd1);
    chk("id_m_data", m_data, 32'h12345678);
    chk("id_m_last", 32'(m_last), 32'd1);
    step();
    chk("id_drain", 32'(m_valid), 32'd0);

    // Reverse map committed while idle
    load_map(1'b1);
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    chk("rev_pending", 32'(commit_pending), 32'd1);
    chk("rev_done_early", 32'(commit_done), 32'd0);
    step();
    chk("rev_pending_clr", 32'(commit_pending), 32'd0);
    chk("rev_done", 32'(commit_done), 32'd1);
    step();
    chk("rev_done_pulse", 32'(commit_done), 32'd0);
    beat(32'h00000001, 1'b1);
    chk("rev_bit0", m_data, 32'h80000000);
    beat(32'h12345678, 1'b1);
    chk("rev_pattern", m_data, 32'h1E6A2C48);
    step();

    // Commit mid-frame: shadow back to identity, active stays reversed until frame end
    load_map(1'b0);
    beat(32'h00000001, 1'b0);
    chk("mf_b1", m_data, 32'h80000000);
    beat(32'h00000002, 1'b0);
    chk("mf_b2", m_data, 32'h40000000);
    cfg_commit = 1'b1;
    beat(32'h00000004, 1'b0);
    cfg_commit = 1'b0;
    chk("mf_b3", m_data, 32'h20000000);
    chk("mf_pending", 32'(commit_pending), 32'd1);
    step();
    chk("mf_gap_pending", 32'(commit_pending), 32'd1);
    chk("mf_gap_done", 32'(commit_done), 32'd0);
    beat(32'h00000008, 1'b1);
    chk("mf_b4", m_data, 32'h10000000);
    chk("mf_b4_last", 32'(m_last), 32'd1);
    chk("mf_done", 32'(commit_done), 32'd1);
    chk("mf_pending_clr", 32'(commit_pending), 32'd0);
    beat(32'h00000010, 1'b1);
    chk("mf_b5", m_data, 32'h00000010);
    chk("mf_done_pulse", 32'(commit_done), 32'd0);
    step();

    // Backpressure with identity map
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 32'hAAAA0001; s_last = 1'b0;
    step();
    chk("bp_first", m_data, 32'hAAAA0001);
    chk("bp_s_ready", 32'(s_ready), 32'd0);
    s_data = 32'hBBBB0002; s_last = 1'b1;
    step();
    chk("bp_hold1", m_data, 32'hAAAA0001);
    step();
    chk("bp_hold2", m_data, 32'hAAAA0001);
    chk("bp_hold_last", 32'(m_last), 32'd0);
    chk("bp_hold_valid", 32'(m_valid), 32'd1);
    m_ready = 1'b1;
    step();
    s_valid = 1'b0;
    chk("bp_second", m_data, 32'hBBBB0002);
    chk("bp_second_last", 32'(m_last), 32'd1);
    step();
    chk("bp_drain", 32'(m_valid), 32'd0);

`ifdef BIT_REORDER_CTRL_PERM_CHECK_EN
    // Duplicate index in shadow is rejected
    cfg_wr_en = 1'b1; cfg_addr = 5'd1; cfg_data = 5'd0;
    step();
    cfg_wr_en = 1'b0;
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    step();
    chk("pc_err", 32'(cfg_err), 32'd1);
    chk("pc_pending_clr", 32'(commit_pending), 32'd0);
    chk("pc_no_done", 32'(commit_done), 32'd0);
    beat(32'h00000002, 1'b1);
    chk("pc_old_map", m_data, 32'h00000002);
    chk("pc_err_sticky", 32'(cfg_err), 32'd1);
    cfg_wr_en = 1'b1; cfg_addr = 5'd1; cfg_data = 5'd1;
    step();
    cfg_wr_en = 1'b0;
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    step();
    chk("pc_err_clr", 32'(cfg_err), 32'd0);
    chk("pc_done", 32'(commit_done), 32'd1);
    step();
`endif

    // Async reset mid-frame with a pending reverse-map commit
    load_map(1'b1);
    beat(32'h00000001, 1'b0);
    cfg_commit = 1'b1;
    beat(32'h00000002, 1'b0);
    cfg_commit = 1'b0;
    chk("ar_pending", 32'(commit_pending), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_m_valid", 32'(m_valid), 32'd0);
    chk("ar_m_data", m_data, 32'h0);
    chk("ar_m_last", 32'(m_last), 32'd0);
    chk("ar_pending_clr", 32'(commit_pending), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    beat(32'hA5A5A5A5, 1'b0);
    chk("ar_a5", m_data, 32'hA5A5A5A5);
    beat(32'h00000001, 1'b1);
    chk("ar_identity", m_data, 32'h00000001);
    chk("ar_no_done", 32'(commit_done), 32'd0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
